arp_rx: RTL



---
 rtl/arp_pkg.sv | 21 ++
 rtl/arp_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/arp_pkg.sv
// Constants and state type shared by the ARP receive and transmit paths.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    // htype=Ethernet, ptype=IPv4, hlen=6, plen=4
    localparam logic [47:0] ARP_HDR_FIXED = 48'h0001_0800_06_04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_ETH_HEAD,
        ST_ARP_DATA,
        ST_RX_END
    } arp_rx_state_t;

endpackage

// File: rtl/arp_rx.sv
// GMII receive parser: validates preamble, Ethernet header and ARP payload for this board.
// Latency: arp_rx_done is high the cycle after the edge sampling ARP byte 27 (50th valid byte).
// Backpressure: none; the GMII stream cannot stall, and dv low mid-frame aborts the frame.
module arp_rx
    import arp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd10}
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_op,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    arp_rx_state_t state, state_nxt;
    logic [5:0]    cnt, cnt_nxt;
    logic          done_nxt;

    logic [47:0] da_sr;
    logic [7:0]  type_hi;
    logic [63:0] hdr_sr;
    logic [79:0] snd_sr;
    logic [23:0] tip_sr;

    logic        eth_ok;
    logic        arp_ok;
    logic [15:0] opcode;

    assign opcode = hdr_sr[15:0];

    assign eth_ok = ((da_sr == BOARD_MAC) || (da_sr == 48'hFFFF_FFFF_FFFF)) &&
                    ({type_hi, gmii_rxd} == ETH_TYPE_ARP);

    // Target IP's last byte is still on the bus when the decision is made.
    assign arp_ok = (hdr_sr[63:16] == ARP_HDR_FIXED) &&
                    ((opcode == ARP_OP_REQ) || (opcode == ARP_OP_REPLY)) &&
                    ({tip_sr, gmii_rxd} == BOARD_IP);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (gmii_rx_dv && gmii_rxd == PREAMBLE_BYTE) begin
                    state_nxt = ST_PREAMBLE;
                    cnt_nxt   = 6'd1;
                end
            end
            ST_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 6'd0;
                end else if (cnt < 6'd7) begin
                    if (gmii_rxd == PREAMBLE_BYTE) begin
                        cnt_nxt = cnt + 6'd1;
                    end else begin
                        state_nxt = ST_RX_END;
                        cnt_nxt   = 6'd0;
                    end
                end else begin
                    state_nxt = (gmii_rxd == SFD_BYTE) ? ST_ETH_HEAD : ST_RX_END;
                    cnt_nxt   = 6'd0;
                end
            end
            ST_ETH_HEAD: begin
                if (!gmii_rx_dv) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 6'd0;
                end else if (cnt == 6'd13) begin
                    state_nxt = eth_ok ? ST_ARP_DATA : ST_RX_END;
                    cnt_nxt   = 6'd0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            ST_ARP_DATA: begin
                if (!gmii_rx_dv) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 6'd0;
                end else if (cnt == 6'd27) begin
                    done_nxt  = arp_ok;
                    state_nxt = ST_RX_END;
                    cnt_nxt   = 6'd0;
                end else begin
                    cnt_nxt = cnt + 6'd1;
                end
            end
            ST_RX_END: begin
                if (!gmii_rx_dv) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = 6'd0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                cnt_nxt   = 6'd0;
            end
        endcase
    end

    // Field capture: each shift register is fully rewritten by every frame.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            da_sr   <= 48'd0;
            type_hi <= 8'd0;
            hdr_sr  <= 64'd0;
            snd_sr  <= 80'd0;
            tip_sr  <= 24'd0;
        end else if (gmii_rx_dv) begin
            if (state == ST_ETH_HEAD) begin
                if (cnt < 6'd6) da_sr <= {da_sr[39:0], gmii_rxd};
                if (cnt == 6'd12) type_hi <= gmii_rxd;
            end
            if (state == ST_ARP_DATA) begin
                if (cnt < 6'd8) hdr_sr <= {hdr_sr[55:0], gmii_rxd};
                if (cnt >= 6'd8 && cnt < 6'd18) snd_sr <= {snd_sr[71:0], gmii_rxd};
                if (cnt >= 6'd24 && cnt < 6'd27) tip_sr <= {tip_sr[15:0], gmii_rxd};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            arp_rx_done <= 1'b0;
            arp_rx_op   <= 1'b0;
            src_mac     <= 48'd0;
            src_ip      <= 32'd0;
        end else begin
            arp_rx_done <= done_nxt;
            if (done_nxt) begin
                arp_rx_op <= (opcode == ARP_OP_REQ);
                src_mac   <= snd_sr[79:32];
                src_ip    <= snd_sr[31:0];
            end
        end
    end

endmodule
